mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the two caches and the external RAM/IO port. It is the responder side of the cache memory protocol (`*_get_en` / `*_out_en`). It arbitrates the dcache and the icache each cycle, with dcache priority, and drives the single-port RAM address/data/write lines. It also throttles IO writes (address space `2'b11`) against `io_buffer_full` and returns one byte per cycle once a burst is streaming.

## Interface
Parameters:
- `ADDR_W`, default 18: cache-side address width; `mem_a` is zero-extended to 32.
- `IO_HOLD`, default 2: cycles IO writes stay blocked after an IO write issues, covering `io_buffer_full` lag.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable. When low, nothing is granted and no `*_out_en` asserts.
- `d_get_en` in 1: dcache request valid.
- `d_write_mode` in 1: 1 = write byte, 0 = read byte.
- `d_addr` in ADDR_W: dcache byte address. Combinational in the dcache and may depend on `d_out_en`.
- `d_data` in 8: dcache write byte.
- `d_out_en` out 1: registered; byte requested last cycle is complete.
- `d_content` out 8: read byte, valid while `d_out_en`.
- `i_get_en` in 1: icache read request.
- `i_addr` in ADDR_W: icache byte address.
- `i_out_en` out 1: registered completion to the icache.
- `i_content` out 8: read byte, valid while `i_out_en`.
- `mem_din` in 8: RAM/IO read data, valid one cycle after the address.
- `mem_dout` out 8: RAM write data.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: 1 = write this cycle.
- `io_buffer_full` in 1: UART output buffer full.

## Operation
- **Per-cycle grant, combinational:**
  - dcache is granted if `d_get_en` is high and it is not IO-blocked.
  - Otherwise icache is granted if `i_get_en` is high.
  - Otherwise there is no grant.
  - An icache burst may be interrupted by dcache on any cycle. The icache simply re-presents its unchanged address.
- **IO-blocked:** `d_addr[ADDR_W-1:ADDR_W-2]==2'b11`, `d_write_mode==1`, and either `io_buffer_full==1` or `hold_cnt!=0`. A blocked dcache request does not fall through to the icache in that cycle; the grant is none.
- **Granted cycle:**
  - `mem_a = {0, addr}` of the winner.
  - `mem_wr = winner is dcache && d_write_mode`.
  - `mem_dout = d_data`.
- **No grant:** `mem_wr=0`, `mem_a=0`, `mem_dout=0`.
- **Completion registers:** `d_out_en <= grant==D`, `i_out_en <= grant==I` (both gated by `rdy_in`). Writes complete one cycle after issue, exactly as reads do.
- **Return data:** `d_content = i_content = mem_din`, combinational pass-through.
- **IO write hold:**
  - A granted IO write loads `hold_cnt <= IO_HOLD`.
  - Otherwise `hold_cnt` decrements to 0 and saturates there.
- **IO reads** (`2'b11` address, read mode) are ordinary reads with no hold.
- **Owner bookkeeping:** a 2-bit `last_grant` register {NONE, D, I} drives the out_en registers.

## Timing
- **Reset values:** `d_out_en=0`, `i_out_en=0`, `hold_cnt=0`, `last_grant=NONE`.
  - Outputs while `rst` is high: `mem_wr=0`, `mem_a=0`, `mem_dout=0`, no grant.
- **Latency:** 1 cycle from a granted request to its `*_out_en`.
- **Streaming:** one byte per cycle. A cache presenting `base + count + out_en` streams 4 bytes in 5 cycles.
- **No combinational loop:** `*_out_en` is a register output, so `d_addr` may depend on it.
- **`rdy_in` low mid-burst:**
  - No grant and `mem_wr=0`.
  - `*_out_en` deasserts next cycle.
  - `hold_cnt` freezes.
  - The burst resumes cleanly, because the cache holds its address.
- **Simultaneous requests:** dcache wins. `i_out_en` stays 0 the next cycle.
- **Last byte:** the cache drops `get_en` in the cycle `out_en` is seen. The controller then grants the other requester in that same cycle with no bubble.
- **Reset mid-burst:** completion of the in-flight byte is discarded and `*_out_en` is 0 next cycle.

## Structure
- Shared package: the IO region prefix `2'b11`, owner encodings NONE/D/I, and the default `IO_HOLD`.
- Single module. The grant logic is small enough that a sub-module is not warranted.

## Test plan
- **dcache word read at 0x00100:** RAM holds 11,22,33,44.
  - `d_out_en` is high on cycles 1..4.
  - `d_content` = 0x11, 0x22, 0x33, 0x44.
  - `mem_a` sequence = 0x100..0x103, then 0.
- **dcache word write-back to 0x00204, data 0xAABBCCDD:**
  - `mem_wr=1` for 4 consecutive cycles with bytes DD, CC, BB, AA at 0x204..0x207.
  - `d_out_en` trails by 1 cycle.
- **icache burst at 0x00040 preempted by a dcache read at 0x00300 on its 2nd byte:**
  - icache byte 0x41 is re-issued after dcache finishes.
  - No `i_out_en` is asserted while `mem_a` is 0x300..0x303.
- **IO write to 0x30000 with `io_buffer_full=1` for 3 cycles:**
  - No grant and `mem_wr=0` for 3 cycles.
  - Granted on cycle 4, then the next IO write is blocked for 2 cycles.
- **`rdy_in` low for 2 cycles mid dcache read:** the burst pauses; data bytes are still correct and in order after resume.
- **`rst` asserted during an icache burst:** `i_out_en=0` and `mem_wr=0` the next cycle; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: IO region prefix,
// grant owner encodings and the default IO write hold time.
package mem_ctrl_pkg;

    localparam logic [1:0] IO_PREFIX       = 2'b11;
    localparam int         IO_HOLD_DEFAULT = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates dcache (priority) and icache onto a
// single RAM/IO port, throttles IO writes, and returns one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int IO_HOLD = IO_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              d_get_en,
    input  logic              d_write_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_data,
    output logic              d_out_en,
    output logic [7:0]        d_content,
    input  logic              i_get_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_out_en,
    output logic [7:0]        i_content,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam int HOLD_W = (IO_HOLD > 1) ? $clog2(IO_HOLD + 1) : 1;

    owner_e            last_grant_q, last_grant_d;
    owner_e            grant;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              d_is_io;
    logic              io_blocked;

    assign d_is_io    = (d_addr[ADDR_W-1 -: 2] == IO_PREFIX);
    assign io_blocked = d_is_io && d_write_mode && (io_buffer_full || (hold_q != '0));

    // State register: owner of the byte issued last cycle, plus the IO hold counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_NONE;
            hold_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
        end
    end

    // Next-state: per-cycle grant. A blocked IO write stalls the port rather
    // than letting the icache slip in ahead of it.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no
        // path through the ifs leaves it unassigned and infers a latch.
        grant  = OWN_NONE;
        hold_d = hold_q;
        if (!rst && rdy_in) begin
            if (d_get_en) begin
                if (!io_blocked) grant = OWN_D;
            end else if (i_get_en) begin
                grant = OWN_I;
            end
            if (grant == OWN_D && d_write_mode && d_is_io) begin
                hold_d = HOLD_W'(IO_HOLD);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
        last_grant_d = grant;
    end

    // Outputs: RAM port driven from the current grant, completions from the register.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (grant)
            OWN_D: begin
                mem_a    = {{(32-ADDR_W){1'b0}}, d_addr};
                mem_dout = d_data;
                mem_wr   = d_write_mode;
            end
            OWN_I: begin
                mem_a    = {{(32-ADDR_W){1'b0}}, i_addr};
                mem_dout = d_data;
            end
            default: ;
        endcase
    end

    assign d_out_en  = (last_grant_q == OWN_D);
    assign i_out_en  = (last_grant_q == OWN_I);
    assign d_content = mem_din;
    assign i_content = mem_din;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model with one-cycle read latency and
// per-scenario tasks stepping the cache side cycle by cycle.
module tb_mem_ctrl;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy_in;
    logic              d_get_en, d_write_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [7:0]        d_data;
    logic              d_out_en;
    logic [7:0]        d_content;
    logic              i_get_en;
    logic [ADDR_W-1:0] i_addr;
    logic              i_out_en;
    logic [7:0]        i_content;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram [1024];

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_HOLD(2)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .d_get_en(d_get_en), .d_write_mode(d_write_mode), .d_addr(d_addr),
        .d_data(d_data), .d_out_en(d_out_en), .d_content(d_content),
        .i_get_en(i_get_en), .i_addr(i_addr), .i_out_en(i_out_en),
        .i_content(i_content), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[9:0]];
        if (mem_wr && mem_a < 32'd1024) ram[mem_a[9:0]] <= mem_dout;
    end

    // Inputs are driven 2 time units after the rising edge, checks 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        d_get_en = 1'b0; d_write_mode = 1'b0; d_addr = '0; d_data = '0;
        i_get_en = 1'b0; i_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        d_get_en = 1'b1; d_write_mode = 1'b1; d_addr = 18'h00204; d_data = 8'h77;
        i_get_en = 1'b1; i_addr = 18'h00040;
        next_cycle();
        next_cycle();
        #1;
        n_cmp += 5;
        if (d_out_en !== 1'b0) begin n_bad++; $display("FAIL reset_d_out_en got=%b exp=0", d_out_en); end
        if (i_out_en !== 1'b0) begin n_bad++; $display("FAIL reset_i_out_en got=%b exp=0", i_out_en); end
        if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dcache_read();
        logic [7:0] exp_b [4];
        logic [31:0] exp_a;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k <= 4; k++) begin
            next_cycle();
            d_get_en = (k < 4); d_write_mode = 1'b0;
            if (k < 4) d_addr = 18'(32'h100 + k);
            exp_a = (k < 4) ? 32'h100 + 32'(k) : 32'h0;
            #1;
            n_cmp += 3;
            if (d_out_en !== (k >= 1)) begin n_bad++; $display("FAIL rd_out_en k=%0d got=%b", k, d_out_en); end
            if (mem_a !== exp_a) begin n_bad++; $display("FAIL rd_mem_a k=%0d got=%h exp=%h", k, mem_a, exp_a); end
            if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rd_mem_wr k=%0d got=%b exp=0", k, mem_wr); end
            if (k >= 1) begin
                n_cmp++;
                if (d_content !== exp_b[k-1]) begin n_bad++; $display("FAIL rd_content k=%0d got=%h exp=%h", k, d_content, exp_b[k-1]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_back();
        logic [7:0] wb [4];
        logic [31:0] exp_a;
        logic [7:0] exp_d;
        wb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int k = 0; k <= 4; k++) begin
            next_cycle();
            d_get_en = (k < 4); d_write_mode = (k < 4);
            if (k < 4) begin d_addr = 18'(32'h204 + k); d_data = wb[k]; end
            exp_a = (k < 4) ? 32'h204 + 32'(k) : 32'h0;
            exp_d = (k < 4) ? wb[k] : 8'h00;
            #1;
            n_cmp += 4;
            if (mem_wr !== (k < 4)) begin n_bad++; $display("FAIL wr_mem_wr k=%0d got=%b", k, mem_wr); end
            if (mem_a !== exp_a) begin n_bad++; $display("FAIL wr_mem_a k=%0d got=%h exp=%h", k, mem_a, exp_a); end
            if (mem_dout !== exp_d) begin n_bad++; $display("FAIL wr_mem_dout k=%0d got=%h exp=%h", k, mem_dout, exp_d); end
            if (d_out_en !== (k >= 1)) begin n_bad++; $display("FAIL wr_out_en k=%0d got=%b", k, d_out_en); end
        end
        idle_inputs();
    endtask

    task automatic test_preempt();
        logic        dg [9], ig [9], doe [9], ioe [9];
        logic [17:0] ia [9];
        logic [31:0] ea [9];
        logic [7:0]  ec [9];
        dg  = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
        ig  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        ia  = '{18'h40, 18'h41, 18'h41, 18'h41, 18'h41, 18'h41, 18'h42, 18'h43, 18'h43};
        ea  = '{32'h40, 32'h300, 32'h301, 32'h302, 32'h303, 32'h41, 32'h42, 32'h43, 32'h0};
        doe = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
        ioe = '{0, 1, 0, 0, 0, 0, 1, 1, 1};
        ec  = '{8'h00, 8'hA0, 8'h50, 8'h51, 8'h52, 8'h53, 8'hA1, 8'hA2, 8'hA3};
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            d_get_en = dg[k]; d_write_mode = 1'b0;
            if (k >= 1 && k <= 4) d_addr = 18'(32'h300 + k - 1);
            i_get_en = ig[k]; i_addr = ia[k];
            #1;
            n_cmp += 3;
            if (mem_a !== ea[k]) begin n_bad++; $display("FAIL pre_mem_a k=%0d got=%h exp=%h", k, mem_a, ea[k]); end
            if (d_out_en !== doe[k]) begin n_bad++; $display("FAIL pre_d_out_en k=%0d got=%b exp=%b", k, d_out_en, doe[k]); end
            if (i_out_en !== ioe[k]) begin n_bad++; $display("FAIL pre_i_out_en k=%0d got=%b exp=%b", k, i_out_en, ioe[k]); end
            if (doe[k]) begin
                n_cmp++;
                if (d_content !== ec[k]) begin n_bad++; $display("FAIL pre_d_content k=%0d got=%h exp=%h", k, d_content, ec[k]); end
            end
            if (ioe[k]) begin
                n_cmp++;
                if (i_content !== ec[k]) begin n_bad++; $display("FAIL pre_i_content k=%0d got=%h exp=%h", k, i_content, ec[k]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_io_block();
        logic        dg [8], full [8], ig [8], ewr [8], doe [8];
        logic [7:0]  dat [8];
        logic [31:0] ea [8];
        dg   = '{1, 1, 1, 1, 1, 1, 1, 0};
        full = '{1, 1, 1, 0, 0, 0, 0, 0};
        ig   = '{1, 1, 1, 0, 0, 0, 0, 0};
        dat  = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5B, 8'h5B, 8'h00};
        ewr  = '{0, 0, 0, 1, 0, 0, 1, 0};
        ea   = '{32'h0, 32'h0, 32'h0, 32'h30000, 32'h0, 32'h0, 32'h30000, 32'h0};
        doe  = '{0, 0, 0, 0, 1, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            d_get_en = dg[k]; d_write_mode = dg[k]; d_addr = 18'h30000; d_data = dat[k];
            io_buffer_full = full[k];
            i_get_en = ig[k]; i_addr = 18'h00010;
            #1;
            n_cmp += 4;
            if (mem_wr !== ewr[k]) begin n_bad++; $display("FAIL io_mem_wr k=%0d got=%b exp=%b", k, mem_wr, ewr[k]); end
            if (mem_a !== ea[k]) begin n_bad++; $display("FAIL io_mem_a k=%0d got=%h exp=%h", k, mem_a, ea[k]); end
            if (d_out_en !== doe[k]) begin n_bad++; $display("FAIL io_d_out_en k=%0d got=%b exp=%b", k, d_out_en, doe[k]); end
            if (i_out_en !== 1'b0) begin n_bad++; $display("FAIL io_i_out_en k=%0d got=%b exp=0", k, i_out_en); end
            if (ewr[k]) begin
                n_cmp++;
                if (mem_dout !== dat[k]) begin n_bad++; $display("FAIL io_mem_dout k=%0d got=%h exp=%h", k, mem_dout, dat[k]); end
            end
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_rdy_pause();
        logic        rdy [7], dg [7], doe [7];
        logic [17:0] da [7];
        logic [31:0] ea [7];
        logic [7:0]  ec [7];
        rdy = '{1, 0, 0, 1, 1, 1, 1};
        dg  = '{1, 1, 1, 1, 1, 1, 0};
        da  = '{18'h100, 18'h101, 18'h101, 18'h101, 18'h102, 18'h103, 18'h103};
        ea  = '{32'h100, 32'h0, 32'h0, 32'h101, 32'h102, 32'h103, 32'h0};
        doe = '{0, 1, 0, 0, 1, 1, 1};
        ec  = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            rdy_in = rdy[k]; d_get_en = dg[k]; d_write_mode = 1'b0; d_addr = da[k];
            #1;
            n_cmp += 3;
            if (mem_a !== ea[k]) begin n_bad++; $display("FAIL rdy_mem_a k=%0d got=%h exp=%h", k, mem_a, ea[k]); end
            if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rdy_mem_wr k=%0d got=%b exp=0", k, mem_wr); end
            if (d_out_en !== doe[k]) begin n_bad++; $display("FAIL rdy_d_out_en k=%0d got=%b exp=%b", k, d_out_en, doe[k]); end
            if (doe[k]) begin
                n_cmp++;
                if (d_content !== ec[k]) begin n_bad++; $display("FAIL rdy_d_content k=%0d got=%h exp=%h", k, d_content, ec[k]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic        rs [4], ig [4], ioe [4];
        logic [17:0] ia [4];
        logic [31:0] ea [4];
        logic [7:0]  ec [4];
        rs  = '{0, 1, 0, 0};
        ig  = '{1, 1, 1, 0};
        ia  = '{18'h40, 18'h41, 18'h42, 18'h42};
        ea  = '{32'h40, 32'h0, 32'h42, 32'h0};
        ioe = '{0, 1, 0, 1};
        ec  = '{8'h00, 8'hA0, 8'h00, 8'hA2};
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            rst = rs[k]; i_get_en = ig[k]; i_addr = ia[k];
            #1;
            n_cmp += 3;
            if (mem_a !== ea[k]) begin n_bad++; $display("FAIL rstb_mem_a k=%0d got=%h exp=%h", k, mem_a, ea[k]); end
            if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rstb_mem_wr k=%0d got=%b exp=0", k, mem_wr); end
            if (i_out_en !== ioe[k]) begin n_bad++; $display("FAIL rstb_i_out_en k=%0d got=%b exp=%b", k, i_out_en, ioe[k]); end
            if (ioe[k]) begin
                n_cmp++;
                if (i_content !== ec[k]) begin n_bad++; $display("FAIL rstb_i_content k=%0d got=%h exp=%h", k, i_content, ec[k]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        for (int j = 0; j < 4; j++) begin
            ram[10'h040 + 10'(j)] = 8'hA0 + 8'(j);
            ram[10'h300 + 10'(j)] = 8'h50 + 8'(j);
        end
        idle_inputs();
        test_reset();
        test_dcache_read();
        test_write_back();
        test_preempt();
        test_io_block();
        test_rdy_pause();
        test_reset_mid_burst();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
